// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_pkg                                                     |
// | Description : Shared UART definitions: FSM state type, parity-mode codes.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_SEND  = 3'd2,
    PARITY_BIT = 3'd3,
    STOP       = 3'd4,
    DONE       = 3'd5
  } uart_state_t;

  localparam logic [1:0] c_par_none = 2'b00;
  localparam logic [1:0] c_par_odd  = 2'b01;
  localparam logic [1:0] c_par_even = 2'b10;

  // Mode name arrives as a packed string of up to 8 characters; unknown names fall back to NONE.
  function automatic logic [1:0] parity_mode(input logic [63:0] mode);
    if (mode == 64'("ODD"))
      return c_par_odd;
    else if (mode == 64'("EVEN"))
      return c_par_even;
    else
      return c_par_none;
  endfunction

endpackage
`default_nettype wire

// File: rtl/txd_baud_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : txd_baud_gen                                                 |
// | Description : Bit-period counter; ticks once every CLK_FREQUENCE/BPS clks. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module txd_baud_gen #(
  parameter int CLK_FREQUENCE = 50_000_000,
  parameter int BPS           = 9600
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic baud_tick
);

  localparam int c_baud_div = CLK_FREQUENCE / BPS;
  localparam int c_cnt_w    = (c_baud_div > 1) ? $clog2(c_baud_div) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_baud_div - 1);

  logic [c_cnt_w-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (!en || (r_cnt == c_cnt_last))
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 1'b1;
  end

  assign baud_tick = en && (r_cnt == c_cnt_last);

endmodule
`default_nettype wire

// File: rtl/uart_txd.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_txd                                                     |
// | Description : UART transmitter: start, LSB-first data, opt. parity, stop.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_txd #(
  parameter int CLK_FREQUENCE = 50_000_000,
  parameter int BPS           = 9600,
  parameter     PARITY        = "NONE",
  parameter int WIDTH         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_start,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_busy,
  output logic             tx_done,
  output logic             uart_tx
);

  import uart_pkg::*;

  localparam logic [1:0] c_par_mode = parity_mode(64'(PARITY));
  localparam bit         c_par_en   = (c_par_mode == c_par_odd) || (c_par_mode == c_par_even);
  localparam int         c_bcw      = $clog2(WIDTH + 1);
  localparam logic [c_bcw-1:0] c_last_bit = c_bcw'(WIDTH - 1);

  uart_state_t      r_state;
  logic [WIDTH-1:0] r_shift;
  logic [c_bcw-1:0] r_bit_cnt;
  logic             r_par_bit;
  logic             w_baud_en;
  logic             w_baud_tick;

  assign w_baud_en = (r_state != IDLE);

  txd_baud_gen #(
    .CLK_FREQUENCE (CLK_FREQUENCE),
    .BPS           (BPS)
  ) u_baud_gen (
    .clk       (clk),
    .rst       (rst),
    .en        (w_baud_en),
    .baud_tick (w_baud_tick)
  );

  // uart_tx is loaded with the next bit on the same edge that changes state,
  // so the line is always a flop output and each bit lasts exactly one baud period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_par_bit <= 1'b0;
      uart_tx   <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (r_state)
        IDLE: begin
          uart_tx   <= 1'b1;
          tx_busy   <= 1'b0;
          r_bit_cnt <= '0;
          if (tx_start) begin
            r_shift   <= tx_data;
            r_par_bit <= (c_par_mode == c_par_odd) ? ~^tx_data : ^tx_data;
            uart_tx   <= 1'b0;
            tx_busy   <= 1'b1;
            r_state   <= START_BIT;
          end
        end
        START_BIT: begin
          if (w_baud_tick) begin
            uart_tx <= r_shift[0];
            r_state <= DATA_SEND;
          end
        end
        DATA_SEND: begin
          if (w_baud_tick) begin
            r_shift   <= {1'b0, r_shift[WIDTH-1:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == c_last_bit) begin
              if (c_par_en) begin
                uart_tx <= r_par_bit;
                r_state <= PARITY_BIT;
              end else begin
                uart_tx <= 1'b1;
                r_state <= STOP;
              end
            end else begin
              uart_tx <= r_shift[1];
            end
          end
        end
        PARITY_BIT: begin
          if (w_baud_tick) begin
            uart_tx <= 1'b1;
            r_state <= STOP;
          end
        end
        STOP: begin
          if (w_baud_tick) begin
            uart_tx <= 1'b1;
            tx_done <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          uart_tx <= 1'b1;
          tx_busy <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          uart_tx <= 1'b1;
          tx_busy <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_txd.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_txd                                                  |
// | Description : Self-checking bench for uart_txd with NONE/EVEN/ODD parity.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_txd;

  localparam int c_clk_freq = 1_000_000;
  localparam int c_bps      = 100_000;
  localparam int c_div      = 10;
  localparam int c_w        = 8;
  localparam int c_none     = 0;
  localparam int c_even     = 1;
  localparam int c_odd      = 2;

  typedef struct {
    int         p;
    logic [7:0] d;
    logic       par;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [2:0]      tx_start = '0;
  logic [2:0][7:0] tx_data  = '0;
  logic [2:0]      tx_busy;
  logic [2:0]      tx_done;
  logic [2:0]      uart_tx;

  int   vectors     = 0;
  int   miscompares = 0;
  vec_t sb[$];
  vec_t tbl[8];

  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam logic [31:0] c_par = (g == c_none) ? 32'("NONE") :
                                      (g == c_even) ? 32'("EVEN") : 32'("ODD");
      uart_txd #(
        .CLK_FREQUENCE (c_clk_freq),
        .BPS           (c_bps),
        .PARITY        (c_par),
        .WIDTH         (c_w)
      ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .tx_start (tx_start[g]),
        .tx_data  (tx_data[g]),
        .tx_busy  (tx_busy[g]),
        .tx_done  (tx_done[g]),
        .uart_tx  (uart_tx[g])
      );
    end
  endgenerate

  function automatic logic model_par(input int p, input logic [7:0] d);
    if (p == c_even) return ^d;
    if (p == c_odd)  return ~^d;
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // One bit period: the line must hold one value for c_div clks with busy high and done low.
  task automatic slot(input int p, input string name, input bit chk, input logic exp_v,
                      output logic got);
    logic first;
    bit   stable;
    stable = 1'b1;
    first  = uart_tx[p];
    for (int i = 0; i < c_div; i++) begin
      if (i > 0) @(negedge clk);
      if (uart_tx[p] !== first || tx_busy[p] !== 1'b1 || tx_done[p] !== 1'b0) stable = 1'b0;
    end
    got = first;
    check({name, " stable"}, 32'(stable), 32'd1);
    if (chk) check(name, 32'(first), 32'(exp_v));
  endtask

  task automatic monitor_frame(input int p, input int timeout);
    vec_t       e;
    logic [7:0] word;
    logic       b;
    bit         seen;
    seen = 1'b0;
    word = '0;
    for (int t = 0; t < timeout; t++) begin
      @(negedge clk);
      if (uart_tx[p] === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    check("start seen", 32'(seen), 32'd1);
    if (!seen) return;
    slot(p, "start", 1'b1, 1'b0, b);
    for (int i = 0; i < c_w; i++) begin
      @(negedge clk);
      slot(p, "data", 1'b0, 1'b0, b);
      word[i] = b;
    end
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard: frame on dut %0d with no expected entry, got %0h", p, word);
      return;
    end
    e = sb.pop_front();
    check("data word", 32'(word), 32'(e.d));
    if (p != c_none) begin
      @(negedge clk);
      slot(p, "parity", 1'b1, e.par, b);
    end
    @(negedge clk);
    slot(p, "stop", 1'b1, 1'b1, b);
    @(negedge clk);
    check("done pulse {done,tx,busy}", 32'({tx_done[p], uart_tx[p], tx_busy[p]}), 32'(3'b111));
    @(negedge clk);
    check("after done {done,busy,tx}", 32'({tx_done[p], tx_busy[p], uart_tx[p]}), 32'(3'b001));
  endtask

  task automatic send(input int p, input logic [7:0] d, input logic par);
    tx_data[p]  = d;
    tx_start[p] = 1'b1;
    sb.push_back('{p, d, par});
    @(posedge clk);
    #1 tx_start[p] = 1'b0;
  endtask

  task automatic expect_quiet(input int p, input string name, input int clks);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < clks; i++) begin
      @(negedge clk);
      if (uart_tx[p] !== 1'b1 || tx_done[p] !== 1'b0 || tx_busy[p] !== 1'b0) ok = 1'b0;
    end
    check(name, 32'(ok), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{c_none, 8'hA5, 1'b0};
    tbl[1] = '{c_even, 8'h03, 1'b0};
    tbl[2] = '{c_odd,  8'h03, 1'b1};
    tbl[3] = '{c_even, 8'h01, 1'b1};
    tbl[4] = '{c_odd,  8'h00, 1'b1};
    tbl[5] = '{c_even, 8'hFF, 1'b0};
    tbl[6] = '{c_odd,  8'h80, 1'b0};
    tbl[7] = '{c_none, 8'h3C, 1'b0};

    repeat (3) @(negedge clk);
    check("reset uart_tx", 32'(uart_tx), 32'(3'b111));
    check("reset busy/done", 32'({tx_busy, tx_done}), 32'(6'b0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      send(tbl[i].p, tbl[i].d, tbl[i].par);
      monitor_frame(tbl[i].p, 20);
    end

    // Request mid-frame must be ignored and must not disturb the frame in flight.
    send(c_none, 8'h5A, 1'b0);
    fork
      begin
        repeat (30) @(posedge clk);
        #1 tx_data[c_none] = 8'hFF;
        tx_start[c_none] = 1'b1;
        @(posedge clk);
        #1 tx_start[c_none] = 1'b0;
      end
    join_none
    monitor_frame(c_none, 20);
    expect_quiet(c_none, "ignored start quiet", 30);

    // Held request: back-to-back frames with a single idle clk between them.
    sb.push_back('{c_even, 8'h55, 1'b0});
    sb.push_back('{c_even, 8'hAA, 1'b0});
    tx_data[c_even]  = 8'h55;
    tx_start[c_even] = 1'b1;
    @(posedge clk);
    #1 tx_data[c_even] = 8'hAA;
    fork
      begin
        repeat (115) @(posedge clk);
        #1 tx_start[c_even] = 1'b0;
      end
    join_none
    monitor_frame(c_even, 20);
    monitor_frame(c_even, 1);
    expect_quiet(c_even, "no third frame", 20);

    // Asynchronous reset mid-frame.
    send(c_odd, 8'hC3, model_par(c_odd, 8'hC3));
    repeat (45) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("async reset {tx,busy}", 32'({uart_tx[c_odd], tx_busy[c_odd]}), 32'(2'b10));
    sb.delete();
    begin
      bit ok;
      ok = 1'b1;
      repeat (3) begin
        @(negedge clk);
        if (tx_done[c_odd] !== 1'b0 || uart_tx[c_odd] !== 1'b1) ok = 1'b0;
      end
      check("no done during reset", 32'(ok), 32'd1);
    end
    rst = 1'b0;
    expect_quiet(c_odd, "quiet after reset", 20);
    send(c_odd, 8'h3C, 1'b1);
    monitor_frame(c_odd, 20);

    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 16; k++) begin
        logic [7:0] d;
        d = 8'($urandom_range(0, 255));
        send(p, d, model_par(p, d));
        monitor_frame(p, 20);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
